mmu_skew_feeder: RTL and testbench

- Upstream stage of the systolic MMU array.
- Accepts one unskewed k-step per beat over a valid/ready stream: N A-row elements and N B-column elements.
- Drives the array edge with diagonally skewed operands: lane i is delayed i cycles.
- Sequences the tile: per-lane clear pulses on the first beat, a flush window, then an N-cycle shift-out window so accumulated results drain from the array.

---
 rtl/mmu_skew_feeder.sv | 155 +++++++++++++++
 tb/tb_mmu_skew_feeder.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_skew_feeder.sv
// -----------------------------------------------------------------------------
// mmu_skew_feeder
//   Upstream stage of the systolic MMU array. Takes one unskewed k-step per
//   beat (N A-row elements + N B-column elements) and drives the array edges
//   with diagonally skewed operands: lane i is delayed by i extra cycles.
//   Sequences the tile: clear pulse travelling with the first beat, a flush
//   window while the last wavefront crosses the array, then an N-cycle
//   shift-out window so the accumulators drain.
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   s_valid/s_ready/s_last, s_a, s_b   input beat stream
//   a_edge, b_edge skewed operands to left / top edge of the array
//   clear_edge     per-lane accumulator clear, skewed with the data
//   shift_edge     shift-out enable for the array's result chain
//   busy           high whenever the FSM is not IDLE
//   done           one-cycle pulse on the last DRAIN cycle
//
// Handshake: a beat transfers on a rising clk edge where s_valid and s_ready
// are both 1. s_ready depends only on state and rst_n (never on s_valid);
// the source must hold the beat stable until it transfers.
// -----------------------------------------------------------------------------
module mmu_skew_feeder #(
   parameter int N        = 4,
   parameter int VAR_SIZE = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  s_last,
   input  logic [N*VAR_SIZE-1:0] s_a,
   input  logic [N*VAR_SIZE-1:0] s_b,
   output logic [N*VAR_SIZE-1:0] a_edge,
   output logic [N*VAR_SIZE-1:0] b_edge,
   output logic [N-1:0]          clear_edge,
   output logic                  shift_edge,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;

   // Counter must hold both the flush load (2N-3) and the drain load (N-1).
   localparam int CW         = (N > 1) ? $clog2(2 * N) : 1;
   localparam int FLUSH_LOAD = (N > 1) ? 2 * N - 3 : 0;
   localparam int DRAIN_LOAD = N - 1;
   localparam bit SKIP_FLUSH = (N == 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          first;

   assign s_ready = rst_n && ((state == IDLE) || (state == STREAM));
   assign accept  = s_valid && s_ready;
   assign first   = accept && (state == IDLE);

   // ---------------------------------------------------------------------------
   // Tile sequencer. Outputs are registered, so each branch sets them for the
   // state being entered.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         shift_edge <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, STREAM: begin
               if (accept) begin
                  busy <= 1'b1;
                  if (s_last) begin
                     if (SKIP_FLUSH) begin
                        state      <= DRAIN;
                        cnt        <= CW'(DRAIN_LOAD);
                        shift_edge <= 1'b1;
                        done       <= (DRAIN_LOAD == 0);
                     end else begin
                        state <= FLUSH;
                        cnt   <= CW'(FLUSH_LOAD);
                     end
                  end else begin
                     state <= STREAM;
                  end
               end
            end
            FLUSH: begin
               if (cnt == '0) begin
                  state      <= DRAIN;
                  cnt        <= CW'(DRAIN_LOAD);
                  shift_edge <= 1'b1;
                  done       <= (DRAIN_LOAD == 0);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DRAIN: begin
               if (cnt == '0) begin
                  state      <= IDLE;
                  shift_edge <= 1'b0;
                  busy       <= 1'b0;
               end else begin
                  cnt  <= cnt - 1'b1;
                  // done lines up with the final DRAIN cycle (count 0).
                  done <= (cnt == CW'(1));
               end
            end
            default: begin
               state      <= IDLE;
               shift_edge <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Skew lines: lane i is a chain of 1+i registers. Cycles without an accepted
   // beat push zeros, which add nothing to the MACs. The first-of-tile flag
   // rides a parallel 1-bit chain so the clear lands with the first operand.
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [VAR_SIZE-1:0] a_sr [0:i];
      logic [VAR_SIZE-1:0] b_sr [0:i];
      logic [i:0]          c_sr;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int j = 0; j <= i; j++) begin
               a_sr[j] <= '0;
               b_sr[j] <= '0;
            end
            c_sr <= '0;
         end else begin
            a_sr[0] <= accept ? s_a[i*VAR_SIZE +: VAR_SIZE] : '0;
            b_sr[0] <= accept ? s_b[i*VAR_SIZE +: VAR_SIZE] : '0;
            c_sr[0] <= first;
            for (int j = 1; j <= i; j++) begin
               a_sr[j] <= a_sr[j-1];
               b_sr[j] <= b_sr[j-1];
               c_sr[j] <= c_sr[j-1];
            end
         end
      end

      assign a_edge[i*VAR_SIZE +: VAR_SIZE] = a_sr[i];
      assign b_edge[i*VAR_SIZE +: VAR_SIZE] = b_sr[i];
      assign clear_edge[i]                  = c_sr[i];
   end

endmodule

// File: tb/tb_mmu_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_mmu_skew_feeder
//   Directed bench for mmu_skew_feeder (N=4, VAR_SIZE=8). Each tile is driven
//   from a per-cycle stimulus table; outputs are captured one step after each
//   rising edge and compared against a table of hand-computed expectations.
//   Cycle numbering: stimulus index k is driven during cycle k, and the
//   capture taken after the edge closing cycle k is cycle k+1.
// -----------------------------------------------------------------------------
module tb_mmu_skew_feeder;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int NW = N * W;
   localparam int MC = 64;

   // kinds of observed signal
   localparam int K_A = 0, K_B = 1, K_CLR = 2, K_SH = 3, K_DN = 4, K_BSY = 5, K_RDY = 6;

   typedef struct {
      string name;
      int    cyc;
      int    kind;
      int    lane;
      int    exp;
   } chk_t;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_valid, s_ready, s_last;
   logic [NW-1:0] s_a, s_b, a_edge, b_edge;
   logic [N-1:0]  clear_edge;
   logic          shift_edge, busy, done;

   always #5 clk = ~clk;

   mmu_skew_feeder #(.N(N), .VAR_SIZE(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_last     (s_last),
      .s_a        (s_a),
      .s_b        (s_b),
      .a_edge     (a_edge),
      .b_edge     (b_edge),
      .clear_edge (clear_edge),
      .shift_edge (shift_edge),
      .busy       (busy),
      .done       (done)
   );

   // ---------------- stimulus / capture storage ----------------
   logic          st_v [0:MC-1];
   logic          st_l [0:MC-1];
   logic          st_r [0:MC-1];
   logic [NW-1:0] st_a [0:MC-1];
   logic [NW-1:0] st_b [0:MC-1];

   logic [NW-1:0] cap_a   [0:MC];
   logic [NW-1:0] cap_b   [0:MC];
   logic [N-1:0]  cap_c   [0:MC];
   logic          cap_sh  [0:MC];
   logic          cap_dn  [0:MC];
   logic          cap_bsy [0:MC];
   logic          cap_rdy [0:MC];

   chk_t tbl[$];
   int   total = 0;
   int   bad   = 0;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NW-1:0] put_lane(logic [NW-1:0] v, int lane, int val);
      logic [NW-1:0] r;
      r = v;
      r[lane*W +: W] = W'(val);
      return r;
   endfunction

   task automatic clear_stim();
      for (int k = 0; k < MC; k++) begin
         st_v[k] = 1'b0;
         st_l[k] = 1'b0;
         st_r[k] = 1'b1;
         st_a[k] = '0;
         st_b[k] = '0;
      end
   endtask

   task automatic run(input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         rst_n   = st_r[k];
         s_valid = st_v[k];
         s_last  = st_l[k];
         s_a     = st_a[k];
         s_b     = st_b[k];
         tick();
         cap_a[k+1]   = a_edge;
         cap_b[k+1]   = b_edge;
         cap_c[k+1]   = clear_edge;
         cap_sh[k+1]  = shift_edge;
         cap_dn[k+1]  = done;
         cap_bsy[k+1] = busy;
         cap_rdy[k+1] = s_ready;
      end
      rst_n   = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_a     = '0;
      s_b     = '0;
   endtask

   // ---------------- scoreboard ----------------
   task automatic cmp(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic add(input string nm, input int c, input int kind, input int lane, input int exp);
      chk_t e;
      e.name = nm;
      e.cyc  = c;
      e.kind = kind;
      e.lane = lane;
      e.exp  = exp;
      tbl.push_back(e);
   endtask

   function automatic int act_of(int kind, int c, int lane);
      logic signed [W-1:0] t;
      case (kind)
         K_A:     begin t = cap_a[c][lane*W +: W]; return int'(t); end
         K_B:     begin t = cap_b[c][lane*W +: W]; return int'(t); end
         K_CLR:   return int'(cap_c[c][lane]);
         K_SH:    return int'(cap_sh[c]);
         K_DN:    return int'(cap_dn[c]);
         K_BSY:   return int'(cap_bsy[c]);
         default: return int'(cap_rdy[c]);
      endcase
   endfunction

   task automatic check_table();
      foreach (tbl[n]) begin
         cmp($sformatf("%s c%0d l%0d", tbl[n].name, tbl[n].cyc, tbl[n].lane),
             act_of(tbl[n].kind, tbl[n].cyc, tbl[n].lane), tbl[n].exp);
      end
      tbl.delete();
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 60) begin
         tick();
         n++;
      end
      cmp("idle_wait busy", int'(busy), 0);
   endtask

   // Single-beat tile, A lanes {1,2,3,4}, B lanes {10,20,30,40}.
   task automatic single_beat_stim();
      clear_stim();
      st_v[0] = 1'b1;
      st_l[0] = 1'b1;
      for (int i = 0; i < N; i++) begin
         st_a[0] = put_lane(st_a[0], i, i + 1);
         st_b[0] = put_lane(st_b[0], i, 10 * (i + 1));
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_a     = '0;
      s_b     = '0;

      // Reset held 3 cycles with random inputs.
      repeat (3) begin
         s_valid = 1'($urandom_range(0, 1));
         s_last  = 1'($urandom_range(0, 1));
         s_a     = NW'($urandom);
         s_b     = NW'($urandom);
         tick();
      end
      cmp("rst a_edge", int'(a_edge != '0), 0);
      cmp("rst b_edge", int'(b_edge != '0), 0);
      cmp("rst clear_edge", int'(clear_edge), 0);
      cmp("rst shift_edge", int'(shift_edge), 0);
      cmp("rst busy", int'(busy), 0);
      cmp("rst done", int'(done), 0);
      cmp("rst s_ready", int'(s_ready), 0);
      rst_n   = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      #1;
      cmp("post-rst s_ready", int'(s_ready), 1);
      tick();
      cmp("post-rst busy", int'(busy), 0);

      // --- Single-beat tile ---
      single_beat_stim();
      run(12);
      for (int c = 1; c <= 11; c++) begin
         for (int i = 0; i < N; i++) begin
            add("t1 a", c, K_A, i, (c == 1 + i) ? i + 1 : 0);
            add("t1 b", c, K_B, i, (c == 1 + i) ? 10 * (i + 1) : 0);
            add("t1 clr", c, K_CLR, i, (c == 1 + i) ? 1 : 0);
         end
         add("t1 shift", c, K_SH, 0, (c >= 7 && c <= 10) ? 1 : 0);
         add("t1 done", c, K_DN, 0, (c == 10) ? 1 : 0);
         add("t1 busy", c, K_BSY, 0, (c <= 10) ? 1 : 0);
         add("t1 ready", c, K_RDY, 0, (c >= 11) ? 1 : 0);
      end
      check_table();
      wait_idle();

      // --- Four beats, A lane0 = 5..8, B lane3 = -1..-4 ---
      clear_stim();
      for (int k = 0; k < 4; k++) begin
         st_v[k] = 1'b1;
         st_a[k] = put_lane('0, 0, 5 + k);
         st_b[k] = put_lane('0, 3, -(k + 1));
      end
      st_l[3] = 1'b1;
      run(15);
      for (int c = 1; c <= 14; c++) begin
         add("t2 a0", c, K_A, 0, (c >= 1 && c <= 4) ? 4 + c : 0);
         add("t2 b3", c, K_B, 3, (c >= 4 && c <= 7) ? -(c - 3) : 0);
         for (int i = 0; i < N; i++)
            add("t2 clr", c, K_CLR, i, (c == 1 + i) ? 1 : 0);
         add("t2 shift", c, K_SH, 0, (c >= 10 && c <= 13) ? 1 : 0);
         add("t2 done", c, K_DN, 0, (c == 13) ? 1 : 0);
      end
      add("t2 busy", 14, K_BSY, 0, 0);
      check_table();
      wait_idle();

      // --- Same stream with a 2-cycle bubble between beats 2 and 3 ---
      // Beats at stimulus indices 0,1,4,5; lane i of beat n: A=10n+i, B=-(n+10(3-i)).
      clear_stim();
      begin
         int pos [4];
         pos = '{0, 1, 4, 5};
         for (int n = 0; n < 4; n++) begin
            st_v[pos[n]] = 1'b1;
            for (int i = 0; i < N; i++) begin
               st_a[pos[n]] = put_lane(st_a[pos[n]], i, 10 * (n + 1) + i);
               st_b[pos[n]] = put_lane(st_b[pos[n]], i, -((n + 1) + 10 * (3 - i)));
            end
         end
         st_l[5] = 1'b1;
      end
      run(17);
      for (int i = 0; i < N; i++) begin
         for (int c = 1 + i; c <= 6 + i; c++) begin
            int idx, n;
            idx = c - 1 - i;
            n   = (idx == 0) ? 1 : (idx == 1) ? 2 : (idx == 4) ? 3 : (idx == 5) ? 4 : 0;
            add("t3 a", c, K_A, i, (n != 0) ? 10 * n + i : 0);
            add("t3 b", c, K_B, i, (n != 0) ? -(n + 10 * (3 - i)) : 0);
            add("t3 clr", c, K_CLR, i, (c == 1 + i) ? 1 : 0);
         end
      end
      for (int c = 1; c <= 5; c++)
         add("t3 ready", c, K_RDY, 0, 1);
      add("t3 ready", 6, K_RDY, 0, 0);
      add("t3 done", 14, K_DN, 0, 0);
      add("t3 done", 15, K_DN, 0, 1);
      add("t3 busy", 16, K_BSY, 0, 0);
      check_table();
      wait_idle();

      // --- s_valid held high through FLUSH/DRAIN ---
      clear_stim();
      for (int k = 0; k < 14; k++) begin
         st_v[k] = 1'b1;
         st_l[k] = 1'b1;
         st_a[k] = put_lane('0, 0, (k == 0) ? 1 : 85);
      end
      run(13);
      add("t4 a0", 1, K_A, 0, 1);
      for (int c = 2; c <= 11; c++) begin
         add("t4 a0", c, K_A, 0, 0);
         add("t4 clr0", c, K_CLR, 0, 0);
      end
      for (int c = 1; c <= 10; c++)
         add("t4 ready", c, K_RDY, 0, 0);
      add("t4 done", 10, K_DN, 0, 1);
      add("t4 ready", 11, K_RDY, 0, 1);
      add("t4 a0", 12, K_A, 0, 85);
      add("t4 clr0", 12, K_CLR, 0, 1);
      add("t4 ready", 12, K_RDY, 0, 0);
      add("t4 busy", 12, K_BSY, 0, 1);
      check_table();
      wait_idle();

      // --- Reset in the 2nd DRAIN cycle (cycle 8) ---
      single_beat_stim();
      st_r[8] = 1'b0;
      run(15);
      add("t5 shift", 7, K_SH, 0, 1);
      add("t5 shift", 8, K_SH, 0, 1);
      add("t5 shift", 9, K_SH, 0, 0);
      add("t5 busy", 9, K_BSY, 0, 0);
      for (int c = 9; c <= 15; c++) begin
         add("t5 done", c, K_DN, 0, 0);
         add("t5 busy", c, K_BSY, 0, 0);
      end
      add("t5 ready", 10, K_RDY, 0, 1);
      check_table();

      // Fresh tile after the abandoned one.
      single_beat_stim();
      run(12);
      add("t6 clr0", 1, K_CLR, 0, 1);
      add("t6 a3", 4, K_A, 3, 4);
      add("t6 b2", 3, K_B, 2, 30);
      add("t6 shift", 6, K_SH, 0, 0);
      add("t6 shift", 7, K_SH, 0, 1);
      add("t6 done", 9, K_DN, 0, 0);
      add("t6 done", 10, K_DN, 0, 1);
      add("t6 busy", 11, K_BSY, 0, 0);
      check_table();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
